noc_router: RTL and testbench

- Single-flit, 5-port mesh NoC router: Local, North, East, South and West ports.
- Each input has a small FIFO; each flit is routed with dimension-ordered XY routing.
- Each output is arbitrated round-robin and drives a registered valid/ready output stage.
- One instance sits at each mesh node, between the local processing element and its four neighbours.

---
 rtl/noc_router.sv | 147 ++++++++++++++
 tb/tb_noc_router.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_router.sv
// Single-flit 5-port mesh router: per-input FIFO, XY routing, round-robin
// arbitration per output into a registered valid/ready output stage.

module noc_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [AW:0]       cnt_q;

  assign rdata_o = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i)  rp_q <= rp_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= wdata_i;
  end
endmodule

module noc_router #(
  parameter int DATA_W = 32,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        in_valid,
  input  logic [5*DATA_W-1:0] in_data,
  output logic [4:0]        in_ready,
  output logic [4:0]        out_valid,
  output logic [5*DATA_W-1:0] out_data,
  input  logic [4:0]        out_ready
);
  localparam int NP = 5;

  logic [NP-1:0][DATA_W-1:0] in_flit, head, od_q, od_d;
  logic [NP-1:0]             full, empty, push, pop;
  logic [NP-1:0]             ov_q, ov_d;
  logic [NP-1:0][2:0]        ptr_q, ptr_d, dst;
  logic [NP-1:0][NP-1:0]     req;

  assign in_flit   = in_data;
  assign in_ready  = {NP{rst_n}} & ~full;
  assign push      = in_valid & in_ready;
  assign out_valid = ov_q;
  assign out_data  = od_q;

  for (genvar p = 0; p < NP; p++) begin : g_in
    noc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(push[p]), .pop_i(pop[p]),
      .wdata_i(in_flit[p]), .rdata_o(head[p]), .empty_o(empty[p]), .full_o(full[p])
    );
  end

  // Ports: 0=L 1=N 2=E 3=S 4=W. X is resolved before Y.
  function automatic logic [2:0] route(input logic [DATA_W-1:0] f);
    logic [3:0] dx, dy;
    dx = f[DATA_W-1 -: 4];
    dy = f[DATA_W-5 -: 4];
    if      (dx > 4'(MY_X)) route = 3'd2;
    else if (dx < 4'(MY_X)) route = 3'd4;
    else if (dy > 4'(MY_Y)) route = 3'd1;
    else if (dy < 4'(MY_Y)) route = 3'd3;
    else                    route = 3'd0;
  endfunction

  // Returns {found, index} of the first requester at or after ptr, mod NP.
  function automatic logic [3:0] pick(input logic [NP-1:0] r, input logic [2:0] ptr);
    int idx;
    pick = '0;
    for (int k = 0; k < NP; k++) begin
      idx = (int'(ptr) + k) % NP;
      if (!pick[3] && r[idx]) pick = {1'b1, 3'(idx)};
    end
  endfunction

  always_comb begin
    req = '0;
    for (int i = 0; i < NP; i++) begin
      dst[i] = route(head[i]);
      for (int o = 0; o < NP; o++)
        req[o][i] = !empty[i] && (dst[i] == 3'(o));
    end
  end

  always_comb begin
    logic [3:0] g;
    ov_d  = ov_q;
    od_d  = od_q;
    ptr_d = ptr_q;
    pop   = '0;
    g     = '0;
    for (int o = 0; o < NP; o++) begin
      g = pick(req[o], ptr_q[o]);
      if ((!ov_q[o] || out_ready[o]) && g[3]) begin
        ov_d[o]    = 1'b1;
        od_d[o]    = head[g[2:0]];
        pop[g[2:0]] = 1'b1;
        ptr_d[o]   = (g[2:0] == 3'd4) ? 3'd0 : g[2:0] + 3'd1;
      end else if (out_ready[o]) begin
        ov_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= '0;
      od_q  <= '0;
      ptr_q <= '0;
    end else begin
      ov_q  <= ov_d;
      od_q  <= od_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_noc_router.sv
// Bench for noc_router at node (1,1): directed scenarios plus a randomized run
// checked cycle by cycle against a queue-based model of the router's rules.

module tb_noc_router;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    in_valid, in_ready, out_valid, out_ready;
  logic [5*DW-1:0] in_data, out_data;

  int checks = 0;
  int failures = 0;

  noc_router #(.DATA_W(DW), .MY_X(1), .MY_Y(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: per-input queues, per-output register and rr pointer.
  logic [DW-1:0] mq [5][$];
  bit            mov [5];
  logic [DW-1:0] mod [5];
  int            mptr [5];

  function automatic int mroute(logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[31:28]);
    dy = int'(f[27:24]);
    if (dx > 1) return 2;
    if (dx < 1) return 4;
    if (dy > 1) return 1;
    if (dy < 1) return 3;
    return 0;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 5; i++) begin
      mq[i].delete();
      mov[i] = 0;
      mod[i] = '0;
      mptr[i] = 0;
    end
  endfunction

  function automatic void mstep();
    bit popm [5];
    bit rdy [5];
    int g, i;
    for (int p = 0; p < 5; p++) begin
      popm[p] = 0;
      rdy[p] = (mq[p].size() < DEPTH);
    end
    for (int o = 0; o < 5; o++) begin
      g = -1;
      if (!mov[o] || out_ready[o])
        for (int k = 0; k < 5; k++) begin
          i = (mptr[o] + k) % 5;
          if (g < 0 && mq[i].size() > 0 && mroute(mq[i][0]) == o) g = i;
        end
      if (g >= 0) begin
        mov[o] = 1;
        mod[o] = mq[g][0];
        popm[g] = 1;
        mptr[o] = (g + 1) % 5;
      end else if (out_ready[o]) mov[o] = 0;
    end
    for (int p = 0; p < 5; p++) begin
      if (popm[p]) void'(mq[p].pop_front());
      if (in_valid[p] && rdy[p]) mq[p].push_back(in_data[p*DW +: DW]);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) mstep();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] od(int o);
    return out_data[o*DW +: DW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 5'h1F;
    mreset();
    #1;
    checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=00000", out_valid); end
    checks++; if (in_ready !== 5'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=00000", in_ready); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 5'h1F) begin failures++; $display("FAIL release_in_ready got=%b exp=11111", in_ready); end
    checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=00000", out_valid); end
  endtask

  task automatic test_routing();
    logic [7:0] hdr [5] = '{8'h21, 8'h01, 8'h12, 8'h10, 8'h11};
    int         exp [5] = '{2, 4, 1, 3, 0};
    logic [DW-1:0] f;
    out_ready = 5'h1F;
    for (int h = 0; h < 5; h++) begin
      f = {hdr[h], 24'($urandom)};
      in_valid = 5'b00001; in_data = '0; in_data[DW-1:0] = f;
      tick();
      in_valid = '0;
      checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL route_early hdr=%h got=%b exp=00000", hdr[h], out_valid); end
      tick();
      checks++; if (out_valid !== 5'(1 << exp[h])) begin failures++; $display("FAIL route_port hdr=%h got=%b exp_port=%0d", hdr[h], out_valid, exp[h]); end
      checks++; if (od(exp[h]) !== f) begin failures++; $display("FAIL route_data hdr=%h got=%h exp=%h", hdr[h], od(exp[h]), f); end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [DW-1:0] f [5];
    out_ready = 5'h1F;
    // Round 1: N,E,S,W to L; L's pointer sits after L from the routing test.
    for (int p = 0; p < 5; p++) begin
      f[p] = {8'h11, 24'($urandom)};
      in_data[p*DW +: DW] = f[p];
    end
    in_valid = 5'b11110;
    tick();
    in_valid = '0;
    for (int k = 1; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 5'b00001 || od(0) !== f[k]) begin failures++; $display("FAIL contend1_slot%0d got v=%b d=%h exp=%h", k, out_valid, od(0), f[k]); end
    end
    // Round 2: all five to L; search restarts at L after W.
    for (int p = 0; p < 5; p++) begin
      f[p] = {8'h11, 24'($urandom)};
      in_data[p*DW +: DW] = f[p];
    end
    in_valid = 5'b11111;
    tick();
    in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 5'b00001 || od(0) !== f[k]) begin failures++; $display("FAIL contend2_slot%0d got v=%b d=%h exp=%h", k, out_valid, od(0), f[k]); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] bp [6];
    int nacc = 0;
    bit acc;
    for (int j = 0; j < 6; j++) bp[j] = {8'h21, 8'(j), 16'($urandom)};
    out_ready = 5'b11011;
    for (int c = 0; c < 10; c++) begin
      in_valid = 5'b10000; in_data[4*DW +: DW] = bp[nacc];
      acc = in_ready[4];
      tick();
      if (acc) nacc++;
      if (c >= 1) begin
        checks++; if (!out_valid[2] || od(2) !== bp[0]) begin failures++; $display("FAIL bp_hold c=%0d got v=%b d=%h exp=%h", c, out_valid[2], od(2), bp[0]); end
      end
    end
    checks++; if (nacc !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", nacc); end
    // Full FIFO pops this edge while W still offers a flit: no bypass.
    out_ready = 5'h1F;
    checks++; if (in_ready[4] !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%b exp=0", in_ready[4]); end
    tick();
    in_valid = '0;
    checks++; if (in_ready[4] !== 1'b1) begin failures++; $display("FAIL after_pop_ready got=%b exp=1", in_ready[4]); end
    for (int j = 1; j < 5; j++) begin
      checks++; if (!out_valid[2] || od(2) !== bp[j]) begin failures++; $display("FAIL bp_drain%0d got v=%b d=%h exp=%h", j, out_valid[2], od(2), bp[j]); end
      tick();
    end
    checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL bp_empty got=%b exp=00000", out_valid); end
  endtask

  task automatic test_throughput();
    logic [DW-1:0] f [20];
    out_ready = 5'h1F;
    for (int c = 0; c <= 20; c++) begin
      if (c < 20) begin
        f[c] = {8'h21, 24'(c * 7 + 3)};
        in_valid = 5'b00001; in_data[DW-1:0] = f[c];
      end else in_valid = '0;
      tick();
      if (c >= 1) begin
        checks++; if (!out_valid[2] || od(2) !== f[c-1]) begin failures++; $display("FAIL tput c=%0d got v=%b d=%h exp=%h", c, out_valid[2], od(2), f[c-1]); end
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] er, ev;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 5; p++) begin
        er[p] = (mq[p].size() < DEPTH);
        ev[p] = mov[p];
      end
      checks++; if (in_ready !== er) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, er); end
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
      for (int o = 0; o < 5; o++)
        if (mov[o]) begin
          checks++; if (od(o) !== mod[o]) begin failures++; $display("FAIL rnd_data c=%0d port=%0d got=%h exp=%h", c, o, od(o), mod[o]); end
        end
      for (int p = 0; p < 5; p++) begin
        in_valid[p] = ($urandom_range(0, 1) == 1);
        in_data[p*DW +: DW] = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 24'($urandom)};
        out_ready[p] = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 5'h1F; out_ready = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=00000", out_valid); end
    checks++; if (in_ready !== 5'b0) begin failures++; $display("FAIL midreset_in_ready got=%b exp=00000", in_ready); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL midreset_out_data got=%h exp=0", out_data); end
    mreset();
    in_valid = '0; out_ready = 5'h1F;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 5'h1F) begin failures++; $display("FAIL midrelease_in_ready got=%b exp=11111", in_ready); end
    checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL midrelease_out_valid got=%b exp=00000", out_valid); end
    // Discarded flits must not reappear after reset.
    repeat (3) begin
      tick();
      checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL post_reset_ghost got=%b exp=00000", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_contention();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
